// File: rtl/adc_bcd_converter.sv
// adc_bcd_converter: scales 12-bit XADC codes to millivolts, converts them to
// 4-digit packed BCD with an iterative double-dabble, and holds the result in
// one of 13 per-channel output registers.
module adc_bcd_converter #(
  parameter int unsigned SCALE    = 1000,
  parameter int unsigned CHANNELS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_code,
  input  logic [3:0]  in_channel,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4,
  output logic [15:0] out5,
  output logic [15:0] out6,
  output logic [15:0] out7,
  output logic [15:0] out8,
  output logic [15:0] out9,
  output logic [15:0] out10,
  output logic [15:0] out11,
  output logic [15:0] out12,
  output logic        done,
  output logic        invalid_ch
);

  localparam logic [25:0] SCALE_W = 26'(SCALE);

  typedef enum logic [1:0] {ST_IDLE, ST_SCALE, ST_CONV, ST_STORE} state_t;

  state_t      state_q, state_d;
  logic [11:0] code_q, code_d;
  logic [3:0]  chan_q, chan_d;
  logic [13:0] mv_q, mv_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sat_q, sat_d;
  logic        done_q, done_d;
  logic        inv_q, inv_d;

  logic [25:0] product;
  logic [13:0] mv_scaled;
  logic [15:0] bcd_adj;
  logic        chan_valid;
  logic [15:0] store_val;
  logic [15:0] out_q [CHANNELS];
  logic [15:0] out_d [CHANNELS];

  // 12x14-bit product; the top 14 bits are the millivolt value
  assign product    = {14'd0, code_q} * SCALE_W;
  assign mv_scaled  = 14'(product >> 12);
  assign chan_valid = (32'(chan_q) < CHANNELS);
  assign store_val  = sat_q ? 16'h9999 : bcd_q;
  assign in_ready   = (state_q == ST_IDLE);

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // Next-state and datapath computation for the conversion FSM
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    chan_d  = chan_q;
    mv_d    = mv_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    inv_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          code_d  = in_code;
          chan_d  = in_channel;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        mv_d    = mv_scaled;
        sat_d   = (mv_scaled > 14'd9999);
        cnt_d   = 4'd0;
        bcd_d   = 16'd0;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        // mv bits shift out of the top of mv into the BCD accumulator
        {bcd_d, mv_d} = {bcd_adj, mv_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = ST_STORE;
      end
      ST_STORE: begin
        if (chan_valid) done_d = 1'b1;
        else            inv_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register FSM state, datapath and the pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      chan_q  <= '0;
      mv_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      chan_q  <= chan_d;
      mv_q    <= mv_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
    end
  end

  // Per-channel result registers, written only in STORE for the addressed channel
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_out
      assign out_d[gi] = (state_q == ST_STORE && chan_q == 4'(gi)) ? store_val : out_q[gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q[gi] <= '0;
        else     out_q[gi] <= out_d[gi];
      end
    end
  endgenerate

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign out2       = out_q[2];
  assign out3       = out_q[3];
  assign out4       = out_q[4];
  assign out5       = out_q[5];
  assign out6       = out_q[6];
  assign out7       = out_q[7];
  assign out8       = out_q[8];
  assign out9       = out_q[9];
  assign out10      = out_q[10];
  assign out11      = out_q[11];
  assign out12      = out_q[12];
  assign done       = done_q;
  assign invalid_ch = inv_q;

endmodule
